// File: rtl/opsel_pkg.sv
// rtl/opsel_pkg.sv - shared constants for the operand-B select stage
//
// Purpose: immediate-extension mode codes and skid-buffer state encoding,
//          shared by opsel_imm_ext and operand_sel_pipe.
// Ports:   none (package)

package opsel_pkg;

    // Immediate extension modes carried on ext_mode
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;
    localparam logic [1:0] EXT_RSVD = 2'b11;

    // Skid-buffer occupancy: nothing held, main entry only, main + skid
    localparam logic [1:0] BUF_EMPTY = 2'b00;
    localparam logic [1:0] BUF_MAIN  = 2'b01;
    localparam logic [1:0] BUF_FULL  = 2'b10;

endpackage

// File: rtl/opsel_imm_ext.sv
// rtl/opsel_imm_ext.sv - combinational immediate extender
//
// Purpose: widens an IMM_W-bit immediate to DATA_W bits using zero, sign or
//          high-half placement. The reserved mode yields zero and raises
//          ext_illegal.
// Ports:
//   imm          in   IMM_W   raw immediate
//   ext_mode     in   2       EXT_ZERO / EXT_SIGN / EXT_HIGH / EXT_RSVD
//   ext_value    out  DATA_W  extended immediate (0 for EXT_RSVD)
//   ext_illegal  out  1       ext_mode is EXT_RSVD

module opsel_imm_ext
    import opsel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        ext_mode,
    output logic [DATA_W-1:0] ext_value,
    output logic              ext_illegal
);

    assign ext_illegal = (ext_mode == EXT_RSVD);

    generate
        if (IMM_W == DATA_W) begin : g_same_width
            // No padding bits exist, so every legal mode is the raw immediate.
            always_comb begin
                ext_value = '0;
                if (ext_mode != EXT_RSVD) begin
                    ext_value = imm;
                end
            end
        end else begin : g_extend
            localparam int PAD = DATA_W - IMM_W;

            always_comb begin
                ext_value = '0;
                case (ext_mode)
                    EXT_ZERO: ext_value = {{PAD{1'b0}}, imm};
                    EXT_SIGN: ext_value = {{PAD{imm[IMM_W-1]}}, imm};
                    EXT_HIGH: ext_value = {imm, {PAD{1'b0}}};
                    default:  ext_value = '0;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/operand_sel_pipe.sv
// rtl/operand_sel_pipe.sv - ALU operand-B select stage with 2-entry skid buffer
//
// Purpose: picks one of NUM_SRC register read ports or an extended immediate
//          and registers the result behind a valid/ready handshake. A main
//          and a skid entry give full throughput with a registered in_ready.
//          Illegal selects pass a zero operand and set the sticky sel_err.
//          Optional forwarding bypass compiled in with macro OPSEL_FWD_EN.
// Ports:
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous active-high reset
//   in_valid   in   1               upstream request valid
//   in_ready   out  1               stage can accept (registered)
//   src_data   in   NUM_SRC*DATA_W  packed register sources, src k at [k*DATA_W +: DATA_W]
//   imm        in   IMM_W           raw immediate
//   sel        in   SEL_W           0..NUM_SRC-1 register, NUM_SRC immediate, above illegal
//   ext_mode   in   2               immediate extension mode
//   fwd_valid  in   1               (OPSEL_FWD_EN) forwarding value valid
//   fwd_sel    in   SEL_W           (OPSEL_FWD_EN) register source being forwarded
//   fwd_data   in   DATA_W          (OPSEL_FWD_EN) forwarded value
//   out_valid  out  1               operand valid
//   out_ready  in   1               downstream accept
//   operand    out  DATA_W          selected/extended operand
//   sel_err    out  1               sticky illegal-input flag

module operand_sel_pipe
    import opsel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [IMM_W-1:0]          imm,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                ext_mode,
`ifdef OPSEL_FWD_EN
    input  logic                      fwd_valid,
    input  logic [SEL_W-1:0]          fwd_sel,
    input  logic [DATA_W-1:0]         fwd_data,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         operand,
    output logic                      sel_err
);

    logic [1:0]        state_q,    state_d;
    logic [DATA_W-1:0] main_q,     main_d;
    logic [DATA_W-1:0] skid_q,     skid_d;
    logic              in_ready_q, in_ready_d;
    logic              sel_err_q,  sel_err_d;

    logic [DATA_W-1:0] ext_value;
    logic              ext_illegal;
    logic [DATA_W-1:0] reg_value;
    logic [DATA_W-1:0] new_operand;
    logic              new_illegal;
    logic              accept;
    logic              drain;

    opsel_imm_ext #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_ext (
        .imm         (imm),
        .ext_mode    (ext_mode),
        .ext_value   (ext_value),
        .ext_illegal (ext_illegal)
    );

    // Register-source mux; the loop keeps every slice index in range even
    // when sel carries an immediate or illegal code.
    always_comb begin
        reg_value = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                reg_value = src_data[k*DATA_W +: DATA_W];
            end
        end
`ifdef OPSEL_FWD_EN
        if (fwd_valid && (fwd_sel == sel) && (sel < SEL_W'(NUM_SRC))) begin
            reg_value = fwd_data;
        end
`endif
    end

    // Final operand for the word on the input port. ext_mode matters only
    // for the immediate select; illegal words still flow, carrying zero.
    always_comb begin
        new_operand = '0;
        new_illegal = 1'b0;
        if (sel < SEL_W'(NUM_SRC)) begin
            new_operand = reg_value;
        end else if (sel == SEL_W'(NUM_SRC)) begin
            new_operand = ext_value;
            new_illegal = ext_illegal;
        end else begin
            new_illegal = 1'b1;
        end
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = (state_q != BUF_EMPTY) & out_ready;

    // Skid-buffer control. Main always feeds the output; skid only fills
    // when main is stalled, so FIFO order is preserved. in_ready is derived
    // from the next state, which keeps it a flop with no path from out_ready.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = sel_err_q | (accept & new_illegal);
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    main_d  = new_operand;
                    state_d = BUF_MAIN;
                end
            end
            BUF_MAIN: begin
                if (accept && drain) begin
                    main_d = new_operand;
                end else if (accept) begin
                    skid_d  = new_operand;
                    state_d = BUF_FULL;
                end else if (drain) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = BUF_MAIN;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
        in_ready_d = (state_d != BUF_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign operand   = main_q;
    assign sel_err   = sel_err_q;

endmodule
